// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin arbiter sharing one FIFO write port between NUM_REQ
//            valid/ready producers, holding each grant for up to BURST_LEN
//            writes. Optional per-requester write counters: ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
`ifdef ARB_STATS_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       wr_en,
  output logic [WIDTH-1:0]           wr_data,
  input  logic                       full,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy
`ifdef ARB_STATS_EN
  , input  logic                     clr_stats,
  output logic [NUM_REQ*CNT_W-1:0]   wr_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0]    C_BURST_LAST = BC_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]   C_LAST_RST   = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] C_ONE        = NUM_REQ'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_last_grant, w_last_nxt;
  logic [BC_W-1:0]    r_burst_cnt, w_burst_nxt;
  logic [IDX_W-1:0]   w_gidx;
  logic [IDX_W-1:0]   w_pick;
  logic               w_found;
  logic               w_gvalid;
  logic               w_xfer;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_gidx = IDX_W'(i);
    end
  end

  // Search starts just after the last released requester, so it ranks lowest.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[wrap_idx(int'(r_last_grant) + k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_idx(int'(r_last_grant) + k);
      end
    end
  end

  assign w_gvalid  = req_valid[w_gidx];
  // No write leaves the block while reset is asserted, even mid-burst.
  assign w_xfer    = (r_state == ST_BUSY) & w_gvalid & ~full & ~rst;
  assign wr_en     = w_xfer;
  assign wr_data   = (r_state == ST_BUSY) ? req_data[int'(w_gidx)*WIDTH +: WIDTH] : '0;
  assign req_ready = r_grant & {NUM_REQ{w_xfer}};
  assign grant     = r_grant;
  assign busy      = (r_state == ST_BUSY);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = C_ONE << w_pick;
          w_burst_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (!w_gvalid || (w_xfer && (r_burst_cnt == C_BURST_LAST))) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = w_gidx;
          w_grant_nxt = '0;
          w_burst_nxt = '0;
        end else if (w_xfer) begin
          w_burst_nxt = r_burst_cnt + BC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= C_LAST_RST;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

`ifdef ARB_STATS_EN
  // Clear has priority over a same-cycle transfer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
        r_cnt <= '0;
      end else if (req_ready[gi]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
    assign wr_count[gi*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule

`default_nettype wire
